// File: rtl/nios_system_pio_rmw_arbiter.sv
// rtl/nios_system_pio_rmw_arbiter.sv - round-robin read-modify-write arbiter for a PIO slave
module nios_system_pio_rmw_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_set_mask,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_clr_mask,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic                          o_busy,
  output logic [2:0]                    o_grant_id,
  output logic [1:0]                    o_avm_address,
  output logic                          o_avm_chipselect,
  output logic                          o_avm_write_n,
  output logic [DATA_WIDTH-1:0]         o_avm_writedata,
  input  logic [DATA_WIDTH-1:0]         i_avm_readdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  // Pointer resets to the last requester so requester 0 has first priority.
  localparam logic [2:0] PTR_RST = 3'(NUM_REQ - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_ptr;
  logic [2:0]            r_grant;
  logic [2:0]            w_sel;
  logic                  w_any;
  logic [7:0]            w_req_ext;
  logic [DATA_WIDTH-1:0] r_set;
  logic [DATA_WIDTH-1:0] r_clr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] w_merged;

  // Requester index k positions after the pointer, wrapping at NUM_REQ.
  function automatic logic [2:0] rr_idx(input logic [2:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[2:0];
  endfunction

  assign w_req_ext = 8'(i_req);
  assign w_any     = |i_req;

  // Set wins over clear; bits in neither mask keep the value read back.
  assign w_merged = (i_avm_readdata & ~r_clr) | r_set;

  // Round-robin pick: scan from farthest to nearest so the nearest pending
  // requester after the pointer is the last (winning) assignment.
  always_comb begin
    w_sel = r_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (w_req_ext[rr_idx(r_ptr, k)]) w_sel = rr_idx(r_ptr, k);
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; the write is skipped when the merge changes nothing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = (w_merged == i_avm_readdata) ? S_ACK : S_WRITE;
      S_WRITE: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant capture, merged-value capture and pointer update.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr   <= PTR_RST;
      r_grant <= '0;
      r_set   <= '0;
      r_clr   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_set   <= i_set_mask[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
            r_clr   <= i_clr_mask[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_READ:  r_wdata <= w_merged;
        S_ACK:   r_ptr   <= r_grant;
        default: ;
      endcase
    end
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_grant_id       = r_grant;
  assign o_avm_address    = 2'b00;
  assign o_avm_chipselect = (r_state == S_READ) || (r_state == S_WRITE);
  assign o_avm_write_n    = (r_state != S_WRITE);
  assign o_avm_writedata  = r_wdata;
  assign o_ack            = (r_state == S_ACK) ? (NUM_REQ'(1) << r_grant) : '0;

endmodule

// File: tb/tb_nios_system_pio_rmw_arbiter.sv
// tb/tb_nios_system_pio_rmw_arbiter.sv - self-checking bench for the PIO RMW arbiter
module tb_nios_system_pio_rmw_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] set_mask;
  logic [NR*DW-1:0] clr_mask;
  logic [NR-1:0]    ack;
  logic             busy;
  logic [2:0]       grant_id;
  logic [1:0]       address;
  logic             cs;
  logic             wn;
  logic [DW-1:0]    wdata;

  logic [DW-1:0]    pio;
  logic             ld;
  logic [DW-1:0]    ld_val;

  int               total = 0;
  int               bad   = 0;
  logic [DW-1:0]    pio_model;
  int               ptr_model;
  logic [DW-1:0]    m_set [NR];
  logic [DW-1:0]    m_clr [NR];
  int               seq [5] = '{0, 1, 2, 3, 0};

  nios_system_pio_rmw_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_req            (req),
    .i_set_mask       (set_mask),
    .i_clr_mask       (clr_mask),
    .o_ack            (ack),
    .o_busy           (busy),
    .o_grant_id       (grant_id),
    .o_avm_address    (address),
    .o_avm_chipselect (cs),
    .o_avm_write_n    (wn),
    .o_avm_writedata  (wdata),
    .i_avm_readdata   (pio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO slave: zero-latency readdata, write on chipselect with write_n low,
  // reset with the system, and preloadable to mimic another master.
  always @(posedge clk or posedge rst) begin
    if (rst)           pio <= '0;
    else if (ld)       pio <= ld_val;
    else if (cs && !wn) pio <= wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] pend);
    for (int k = 1; k <= NR; k++) begin
      if (pend[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return 0;
  endfunction

  task automatic raise(input int id, input logic [DW-1:0] s, input logic [DW-1:0] c);
    m_set[id] = s;
    m_clr[id] = c;
    set_mask[id*DW +: DW] = s;
    clr_mask[id*DW +: DW] = c;
    req[id] = 1'b1;
  endtask

  task automatic preload(input logic [DW-1:0] v);
    ld = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld = 1'b0;
    pio_model = v;
  endtask

  // Expects the DUT idle with requester id about to be granted at the next edge.
  task automatic serve(input int id, input bit keep);
    logic [DW-1:0] exp_v;
    bit wr;
    exp_v = (pio_model & ~m_clr[id]) | m_set[id];
    wr = (exp_v != pio_model);
    @(negedge clk);
    check("rd_busy", 32'(busy), 1);
    check("rd_cs", 32'(cs), 1);
    check("rd_wn", 32'(wn), 1);
    check("rd_grant", 32'(grant_id), id);
    check("rd_ack", 32'(ack), 0);
    set_mask[id*DW +: DW] = $urandom;
    clr_mask[id*DW +: DW] = $urandom;
    if (wr) begin
      @(negedge clk);
      check("wr_cs", 32'(cs), 1);
      check("wr_wn", 32'(wn), 0);
      check("wr_data", wdata, exp_v);
      check("wr_ack", 32'(ack), 0);
    end
    @(negedge clk);
    check("ack_onehot", 32'(ack), 32'(1) << id);
    check("ack_busy", 32'(busy), 1);
    check("ack_cs", 32'(cs), 0);
    check("ack_wn", 32'(wn), 1);
    set_mask[id*DW +: DW] = m_set[id];
    clr_mask[id*DW +: DW] = m_clr[id];
    if (!keep) req[id] = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_ack", 32'(ack), 0);
    check("pio_value", pio, exp_v);
    pio_model = exp_v;
    ptr_model = id;
  endtask

  initial begin
    int id;
    req = '0; set_mask = '0; clr_mask = '0;
    ld = 1'b0; ld_val = '0; rst = 1'b1;
    pio_model = '0; ptr_model = NR - 1;
    for (int i = 0; i < NR; i++) begin m_set[i] = '0; m_clr[i] = '0; end
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_cs", 32'(cs), 0);
    check("rst_wn", 32'(wn), 1);
    check("rst_wdata", wdata, 0);
    check("rst_addr", 32'(address), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", 32'(busy), 0);

    raise(0, 32'h0000_00F0, 32'h0);
    serve(0, 1'b0);
    check("single_pio", pio, 32'h0000_00F0);

    preload(32'hFFFF_0000);
    raise(1, 32'h0000_0001, 32'h0001_0001);
    serve(1, 1'b0);
    check("overlap_pio", pio, 32'hFFFE_0001);

    preload(32'h0000_00F0);
    raise(2, 32'h0000_0010, 32'h0);
    serve(2, 1'b0);
    check("noop_pio", pio, 32'h0000_00F0);

    raise(0, 32'h0000_0004, 32'h0);
    serve(0, 1'b0);

    raise(1, 32'h0000_0100, 32'h0);
    @(negedge clk);
    check("mid_rd_cs", 32'(cs), 1);
    @(negedge clk);
    check("mid_wr_wn", 32'(wn), 0);
    rst = 1'b1;
    raise(0, 32'h0000_0002, 32'h0);
    #1;
    check("mid_rst_cs", 32'(cs), 0);
    check("mid_rst_wn", 32'(wn), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_grant", 32'(grant_id), 0);
    @(negedge clk);
    check("mid_rst_ack2", 32'(ack), 0);
    rst = 1'b0;
    pio_model = '0;
    ptr_model = NR - 1;
    serve(0, 1'b0);
    serve(1, 1'b0);
    check("mid_after_pio", pio, 32'h0000_0102);

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NR; i++) raise(i, 32'(1) << (8 * i), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pio_model = '0;
    ptr_model = NR - 1;
    for (int k = 0; k < 5; k++) serve(seq[k], 1'b1);
    req = '0;
    check("rr_pio", pio, 32'h0101_0101);

    for (int n = 0; n < 40; n++) begin
      if (req == '0 && $urandom_range(0, 2) == 0) preload($urandom);
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 3) == 0) raise(i, 32'h0, 32'h0);
          else raise(i, $urandom & $urandom, $urandom & $urandom);
        end
      end
      if (req == '0) raise(int'($urandom_range(0, NR - 1)), $urandom & $urandom, $urandom);
      id = rr_pick(ptr_model, req);
      serve(id, 1'b0);
    end
    req = '0;
    @(negedge clk);
    check("end_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios_system_pio_rmw_arbiter.md
# nios_system_pio_rmw_arbiter

Round-robin read-modify-write arbiter for one 32-bit Avalon-MM output PIO slave. Up to NUM_REQ hardware agents each own arbitrary bits of the PIO output port. An agent requests "set these bits, clear those bits". The block serialises requests, reads the PIO data register, merges the masks, and writes back, so agents never clobber each other's bits. It sits between the agent logic and the PIO `s1` slave in the Qsys system, as the PIO's only master.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 1..8
- DATA_WIDTH, 32: PIO data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held high until matching ack
- set_mask  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; 1 = force bit high
- clr_mask  in  NUM_REQ*DATA_WIDTH  same slicing; 1 = force bit low
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- busy  out  1  high in any state except IDLE
- grant_id  out  3  index of requester being served; valid while busy
- avm_address  out  2  constant 0
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  DATA_WIDTH  merged value
- avm_readdata  in  DATA_WIDTH  PIO readdata; combinational from slave, zero-latency

## Operation
- Reset values:
  - ack = 0, busy = 0, grant_id = 0
  - avm_chipselect = 0, avm_write_n = 1, avm_writedata = 0
  - rr pointer = NUM_REQ-1, so requester 0 has first priority
- FSM states: IDLE, READ, WRITE, ACK.
- IDLE:
  - If any req bit is set, select the first set bit searching from pointer+1 upward, with wrap-around.
  - Latch its set_mask/clr_mask and grant_id, then go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Drive chipselect=1, write_n=1.
  - Capture avm_readdata into cur at the clock edge.
  - Compute nxt = (cur & ~clr) | set; set wins when a bit is in both masks.
  - If nxt == cur, go to ACK (write skipped). Otherwise go to WRITE.
- WRITE:
  - Drive chipselect=1, write_n=0, writedata=nxt for exactly one cycle, then go to ACK.
- ACK:
  - Pulse ack[grant_id], update pointer = grant_id, go to IDLE.
- Masks are sampled only in IDLE at grant. Changes to masks after grant are ignored until the next request.
- A requester whose req is still high in the cycle after its ack is treated as a new request. Round-robin places it behind the other pending requesters.
- Requests from non-granted agents stay pending indefinitely; none are dropped.
- Masks of zero are legal: nxt == cur, so no write occurs and ack is still issued.
- Bits touched by no requester keep their current value, including values written by other masters before this block owned the slave.

## Timing
- Cycle-level sequence, with req seen in IDLE at edge 0:
  - READ during cycle 1
  - WRITE during cycle 2
  - ack high during cycle 3
  - IDLE at cycle 4; next grant evaluated at edge 4
- Worst-case latency:
  - Per grant: 4 cycles with a write, 3 cycles when the write is skipped.
  - A starved requester waits at most NUM_REQ-1 full grants.
- The write is visible on the PIO out_port from the edge ending the WRITE cycle, i.e. before ack is seen.
- Combinational outputs are decoded from registered state only; none depend combinationally on req.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with all outputs at reset values; no ack is issued.
  - If reset lands during WRITE, the PIO register is also reset by the system, so there is no partial state.

## Test plan
- Single request: PIO=0x0000_0000, req0 with set=0x0000_00F0, clr=0. Required:
  - READ cycle 1, WRITE 0x0000_00F0 in cycle 2, ack[0] in cycle 3.
  - PIO=0x0000_00F0.
- Set/clear overlap: PIO=0xFFFF_0000, req1 with set=0x0000_0001, clr=0x0001_0001. Required:
  - writedata=0xFFFE_0001.
  - busy high for cycles 1-3.
- No-op skip: PIO=0x0000_00F0, req2 with set=0x0000_0010. Required:
  - write_n never low.
  - ack[2] in cycle 2, total busy 2 cycles.
- Round robin: req0-3 all held from reset, each with a distinct single bit. Required:
  - Acks in order 0,1,2,3 then 0 again if req0 remains high.
  - Final PIO holds all four bits.
- Reset mid-op: assert reset during a WRITE cycle. Required:
  - chipselect=0, write_n=1, busy=0, ack=0 at the next sampling point.
  - After release, the pending request is re-served from IDLE with the pointer at NUM_REQ-1.
